// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared definitions for the SPI SCLK engine: spi_mode
//               encodings, frame-sequencer state encoding and the helper
//               that derives the baud-rate divisor width.
//               Optional macro SPI_SS_GUARD_EN adds the guard states.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // spi_mode encodings; any value with bit 1 set is treated as STOP
    localparam logic [1:0] SPI_RUN  = 2'b00;
    localparam logic [1:0] SPI_WAIT = 2'b01;
    localparam logic [1:0] SPI_STOP = 2'b10;

    // Frame sequencer states
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ACTIVE     = 3'd1,
`ifdef SPI_SS_GUARD_EN
        ST_GUARD_PRE  = 3'd2,
        ST_GUARD_POST = 3'd3,
`endif
        ST_FINISH     = 3'd4
    } spi_state_e;

    // Widest divisor is (2^pre_w) << (2^rate_w), which needs this many bits
    function automatic int spi_div_width(input int pre_w, input int rate_w);
        return pre_w + (1 << rate_w) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_div_counter.sv
`default_nettype none
// ============================================================================
// Module      : spi_div_counter
// Description : Half-period counter for the SPI SCLK engine. Counts
//               0..half-1 while enabled, holds while frozen, clears to zero
//               outside a frame and flags the last count with o_wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_div_counter #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_half,
    output logic             o_wrap
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_last;

    // A half of zero cannot occur with a legal divisor; treat it as one
    assign w_last = (i_half == '0) ? '0 : (i_half - CNT_W'(1));
    assign o_wrap = i_en && !i_clear && (r_count >= w_last);

    // Count up while enabled, restart after the last count, hold when frozen
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_wrap ? '0 : (r_count + CNT_W'(1));
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_sclk_engine.sv
`default_nettype none
// ============================================================================
// Module      : spi_sclk_engine
// Description : SPI serial-clock engine. Derives SCLK from PCLK with a
//               programmable divisor, frames transfers with ss_n, counts
//               2*frame_len SCLK edges and issues shift/sample strobes one
//               PCLK ahead of each edge. Freezes in STOP or WAIT+spiswai.
//               Optional macro SPI_SS_GUARD_EN inserts a half-period guard
//               between ss_n assertion/deassertion and the SCLK edges.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sclk_engine
    import spi_pkg::*;
#(
    parameter int PRE_W  = 3,
    parameter int RATE_W = 3,
    parameter int LEN_W  = 5,
    parameter int DIV_W  = spi_div_width(PRE_W, RATE_W)
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [1:0]        spi_mode,
    input  logic              spiswai,
    input  logic [PRE_W-1:0]  sppr,
    input  logic [RATE_W-1:0] spr,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              ss_n,
    output logic              sclk,
    output logic              shift_stb,
    output logic              sample_stb,
    output logic [DIV_W-1:0]  baudratedivisor
);

    localparam int c_HALF_W = DIV_W - 1;
    localparam int c_EDGE_W = LEN_W + 1;

`ifdef SPI_SS_GUARD_EN
    localparam spi_state_e c_FIRST_STATE = ST_GUARD_PRE;
    localparam spi_state_e c_AFTER_EDGES = ST_GUARD_POST;
`else
    localparam spi_state_e c_FIRST_STATE = ST_ACTIVE;
    localparam spi_state_e c_AFTER_EDGES = ST_FINISH;
`endif

    spi_state_e          r_state;
    spi_state_e          w_state_next;
    logic [c_HALF_W-1:0] r_half;
    logic [LEN_W-1:0]    r_len;
    logic                r_cpha;
    logic [c_EDGE_W-1:0] r_edges;
    logic                r_sclk;
    logic                r_ss_n;
    logic                r_busy;
    logic                r_done;

    logic [DIV_W-1:0]    w_divisor;
    logic [c_EDGE_W-1:0] w_edge_total;
    logic                w_edges_done;
    logic                w_frozen;
    logic                w_accept;
    logic                w_in_frame;
    logic                w_next_in_frame;
    logic                w_wrap;
    logic                w_toggle;
    logic                w_shift;
    logic                w_sample;

    // Divisor follows the live register fields with no pipeline delay
    assign w_divisor = (DIV_W'(sppr) + DIV_W'(1)) << ((RATE_W + 1)'(spr) + (RATE_W + 1)'(1));

    assign w_frozen     = ((spi_mode == SPI_WAIT) && spiswai) || spi_mode[1];
    assign w_edge_total = {r_len, 1'b0};
    assign w_edges_done = (r_edges == w_edge_total);
    // FINISH behaves like IDLE for acceptance so back-to-back frames chain
    assign w_accept     = ((r_state == ST_IDLE) || (r_state == ST_FINISH)) && start
                          && (frame_len != '0) && !w_frozen;

`ifdef SPI_SS_GUARD_EN
    assign w_in_frame      = (r_state == ST_ACTIVE) || (r_state == ST_GUARD_PRE)
                             || (r_state == ST_GUARD_POST);
    assign w_next_in_frame = (w_state_next == ST_ACTIVE) || (w_state_next == ST_GUARD_PRE)
                             || (w_state_next == ST_GUARD_POST);
`else
    assign w_in_frame      = (r_state == ST_ACTIVE);
    assign w_next_in_frame = (w_state_next == ST_ACTIVE);
`endif

    assign w_toggle = (r_state == ST_ACTIVE) && w_wrap && !w_edges_done;

    spi_div_counter #(
        .CNT_W (c_HALF_W)
    ) u_div_counter (
        .clk     (PCLK),
        .rst     (PRESET),
        .i_clear (!w_in_frame),
        .i_en    (w_in_frame && !w_frozen),
        .i_half  (r_half),
        .o_wrap  (w_wrap)
    );

    // State register
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and strobe decode; the wrap pulse is already gated by freeze
    always_comb begin
        w_state_next = r_state;
        w_shift      = 1'b0;
        w_sample     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = c_FIRST_STATE;
                end
            end
`ifdef SPI_SS_GUARD_EN
            ST_GUARD_PRE: begin
                if (w_wrap) begin
                    w_state_next = ST_ACTIVE;
                end
            end
            ST_GUARD_POST: begin
                if (w_wrap) begin
                    w_state_next = ST_FINISH;
                end
            end
`endif
            ST_ACTIVE: begin
                if (w_wrap) begin
                    if (w_edges_done) begin
                        w_state_next = c_AFTER_EDGES;
                    end else if (!r_edges[0]) begin
                        // upcoming edge number is odd
                        if (r_cpha) w_shift  = 1'b1;
                        else        w_sample = 1'b1;
                    end else begin
                        // upcoming edge number is even; no shift after the last edge
                        if (r_cpha) begin
                            w_sample = 1'b1;
                        end else if (r_edges != (w_edge_total - c_EDGE_W'(1))) begin
                            w_shift = 1'b1;
                        end
                    end
                end
            end
            // Completion is a single cycle and is not stretched by a freeze
            ST_FINISH: begin
                w_state_next = w_accept ? c_FIRST_STATE : ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Frame configuration captured at acceptance; later changes are ignored
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_half <= '0;
            r_len  <= '0;
            r_cpha <= 1'b0;
        end else if (w_accept) begin
            r_half <= w_divisor[DIV_W-1:1];
            r_len  <= frame_len;
            r_cpha <= cpha;
        end
    end

    // Count SCLK edges produced in the current frame
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_edges <= '0;
        end else if (w_accept) begin
            r_edges <= '0;
        end else if (w_toggle) begin
            r_edges <= r_edges + c_EDGE_W'(1);
        end
    end

    // SCLK: idles at cpol, toggles on each half-period wrap within the frame
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_sclk <= 1'b0;
        end else if (w_accept) begin
            r_sclk <= cpol;
        end else if ((r_state == ST_IDLE) && !w_frozen) begin
            r_sclk <= cpol;
        end else if (w_toggle) begin
            r_sclk <= ~r_sclk;
        end
    end

    // Framing outputs registered from the next state so they change with it
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_ss_n <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_ss_n <= !w_next_in_frame;
            r_busy <= w_next_in_frame;
            r_done <= (w_state_next == ST_FINISH);
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign ss_n            = r_ss_n;
    assign sclk            = r_sclk;
    assign shift_stb       = w_shift;
    assign sample_stb      = w_sample;
    assign baudratedivisor = w_divisor;

endmodule
`default_nettype wire

// File: doc/spi_sclk_engine.md
# spi_sclk_engine

- Parametrised successor to the SPI baud-rate generator: derives SCLK from PCLK with a programmable divisor.
- Adds frame sequencing the earlier generator lacks: start/done handshake, automatic slave-select framing, and a programmable frame length.
- Issues shift and sample strobes one PCLK ahead of each SCLK edge; these drive the SPI shift register.
- Sits between the APB register slice (config, start) and the shifter/pad logic.

## Interface
- PRE_W, 3: width of sppr prescaler field.
- RATE_W, 3: width of spr rate field.
- LEN_W, 5: width of frame_len; max frame = 2^LEN_W-1 bits.
- DIV_W, PRE_W+2^RATE_W+1: divisor width (12 at defaults).
- PCLK  in  1  clock.
- PRESET  in  1  synchronous, active-high reset.
- spi_mode  in  2  00 RUN, 01 WAIT, 1x STOP.
- spiswai  in  1  stop-in-wait enable.
- sppr  in  PRE_W  prescaler select.
- spr  in  RATE_W  rate select.
- cpol, cpha  in  1  clock polarity/phase.
- frame_len  in  LEN_W  bits per frame.
- start  in  1  frame request (level-sampled).
- busy  out  1  frame in progress.
- done  out  1  one-cycle frame-complete pulse.
- ss_n  out  1  slave select, active low.
- sclk  out  1  serial clock.
- shift_stb, sample_stb  out  1  one-cycle strobes preceding an SCLK edge.
- baudratedivisor  out  DIV_W  (sppr+1) << (spr+1), combinational from live inputs.

## Operation
- Reset values: busy 0, done 0, ss_n 1, sclk 0, strobes 0, internal counters 0.
- States: IDLE, ACTIVE, (GUARD_PRE, GUARD_POST with macro), FINISH.
- IDLE:
  - sclk register reloads cpol each cycle.
  - start accepted when busy=0, frame_len≠0, and the block is not frozen.
  - On acceptance, cpol, cpha, frame_len and divisor are latched; mid-frame config changes are ignored.
- start with frame_len=0 is ignored: no ss_n, no done.
- half = latched divisor/2 (≥1). The half-period counter runs 0..half-1.
- ACTIVE:
  - Each counter wrap toggles sclk until 2·frame_len edges have been produced.
  - One further half period follows, then FINISH.
- FINISH (one cycle): ss_n=1, done=1, busy=0 → IDLE.
- Strobes, asserted in the cycle the counter is at half-1 before edge k (k=1..2N):
  - cpha=0: sample_stb before odd k; shift_stb before even k except k=2N.
  - cpha=1: shift_stb before odd k; sample_stb before even k.
- Freeze when (spi_mode=01 and spiswai=1) or spi_mode[1]=1:
  - Counter, sclk, ss_n and state hold.
  - No strobes; start is ignored.
  - Resumes exactly where it stopped.
- PRESET mid-frame: immediate return to reset values; no done.

## Timing
- Start accepted in cycle S (start=1, busy=0).
- S+1: ss_n=0, busy=1.
- Edge k visible on sclk at S+1+k·half.
- S+1+(2N+1)·half: ss_n=1, done=1, busy=0.
- Strobe for edge k at S+k·half.
- Back-to-back: start held high during the done cycle is accepted. ss_n is high for exactly one cycle between frames.
- baudratedivisor: zero latency; sclk period = divisor PCLK cycles.

## Configuration
- SPI_SS_GUARD_EN defined:
  - Adds GUARD_PRE and GUARD_POST, each one half period long.
  - Edge k moves to S+1+(k+1)·half.
  - done moves to S+1+(2N+3)·half.
  - Strobe timing stays one cycle before each edge.
- SPI_SS_GUARD_EN undefined: guard states absent; timing as above.

## Structure
- Shared package spi_pkg:
  - spi_mode encodings (SPI_RUN, SPI_WAIT, SPI_STOP).
  - State enum.
  - Divisor-width function used to derive DIV_W.
- One sub-module, spi_div_counter: half-period counter with enable/freeze and wrap pulse.
- The top level holds the FSM, edge counter, sclk/ss_n registers and strobe decode.

## Test plan
- sppr=0, spr=0 (divisor 2), cpol=0, cpha=0, N=8, start at S:
  - ss_n low at S+1.
  - 16 edges at S+2..S+17.
  - done at S+18.
  - 8 sample_stb, 7 shift_stb.
- sppr=2, spr=1 (divisor 12), cpol=1, cpha=1, N=4:
  - sclk idles 1; edges every 6 cycles.
  - Shift before odd edges, sample before even.
  - done at S+1+9·6.
- WAIT with spiswai=1 asserted for 20 cycles mid-frame:
  - sclk, ss_n and counter frozen; no strobes; start ignored.
  - Completion shifted exactly 20 cycles.
- PRESET at edge 5: next cycle ss_n=1, sclk=0, busy=0, no done; a new start then works normally.
- Back-to-back starts: ss_n high exactly one cycle between frames. frame_len=0 start: no activity.
- SPI_SS_GUARD_EN build with divisor 4, N=2: first edge at S+5, done at S+15.
